// File: rtl/word_serializer.sv
// Byte-to-serial line transmitter: 8N1 framing, LSB first, with a fixed
// number of sysclk cycles per bit. The line output is registered.
module word_serializer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] word,
    output logic       out,
    output logic       status,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          out_n, done_n;
    logic          bit_end;

    assign bit_end = (cnt == LAST);
    assign status  = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= 8'h00;
            out   <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            out   <= out_n;
            done  <= done_n;
        end
    end

    // out is decoded from the current state and registered, so the line
    // trails the state register by exactly one cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        out_n   = 1'b1;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = START;
                    shreg_n = word;
                    idx_n   = 3'd0;
                end
            end
            START: begin
                out_n = 1'b0;
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                out_n = shreg[0];
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                out_n = 1'b1;
                if (bit_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
